cam_pipe: RTL and testbench

//   Pipelined, parametrised CAM with a valid/ready op channel and a response channel.

---
 rtl/cam_pipe.sv | 230 +++++++++++++++++++++++
 tb/tb_cam_pipe.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pipe.sv
// Pipelined CAM with valid/ready op and response channels: SEARCH, WRITE, INSERT, INVALIDATE.
// Optional ternary compare (per-entry stored mask) enabled by defining CAM_TERNARY_EN.
module cam_pipe #(
    parameter int unsigned CAM_WIDTH = 32,
    parameter int unsigned CAM_DEPTH = 16,
    localparam int unsigned IDX_W    = $clog2(CAM_DEPTH),
    localparam int unsigned CNT_W    = $clog2(CAM_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 op_vld,
    output logic                 op_rdy,
    input  logic [1:0]           op_code,
    input  logic [IDX_W-1:0]     op_idx,
    input  logic [CAM_WIDTH-1:0] op_data,
`ifdef CAM_TERNARY_EN
    input  logic [CAM_WIDTH-1:0] op_mask,
`endif
    output logic                 rsp_vld,
    input  logic                 rsp_rdy,
    output logic                 rsp_hit,
    output logic                 rsp_multi,
    output logic [IDX_W-1:0]     rsp_index,
    output logic [CNT_W-1:0]     used_cnt,
    output logic                 full
);

    localparam logic [1:0] OP_SEARCH = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_INSERT = 2'b10;
    localparam logic [1:0] OP_INVAL  = 2'b11;

    logic [CAM_WIDTH-1:0] r_data  [CAM_DEPTH];
    logic [CAM_WIDTH-1:0] w_emask [CAM_DEPTH];
    logic [CAM_DEPTH-1:0] r_valid;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_full;

    logic [CAM_DEPTH-1:0] w_match;
    logic [IDX_W-1:0]     w_free_idx;
    logic                 w_free_any;
    logic                 w_idx_ok;
    logic                 w_idx_vld;
    logic                 w_accept;
    logic                 w_set_en;
    logic [IDX_W-1:0]     w_set_idx;
    logic                 w_clr_en;
    logic                 w_cnt_inc;
    logic                 w_cnt_dec;
    logic [CNT_W-1:0]     w_cnt_nxt;
    logic                 w_op_hit;
    logic [IDX_W-1:0]     w_op_index;
    logic                 w_adv_s1;
    logic                 w_adv_s2;

    logic                 r_s1_vld;
    logic                 r_s1_srch;
    logic [CAM_DEPTH-1:0] r_s1_match;
    logic                 r_s1_hit;
    logic [IDX_W-1:0]     r_s1_idx;

    logic [IDX_W-1:0]     w_enc_idx;
    logic                 w_enc_hit;
    logic                 w_enc_multi;

    logic                 r_rsp_vld;
    logic                 r_rsp_hit;
    logic                 r_rsp_multi;
    logic [IDX_W-1:0]     r_rsp_index;

`ifdef CAM_TERNARY_EN
    logic [CAM_WIDTH-1:0] r_mask [CAM_DEPTH];

    // Stored don't-care mask, written alongside the key
    always_ff @(posedge clk) begin
        if (w_set_en) begin
            r_mask[w_set_idx] <= op_mask;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(CAM_DEPTH); i++) begin
            w_emask[i] = r_mask[i];
        end
    end
`else
    always_comb begin
        for (int i = 0; i < int'(CAM_DEPTH); i++) begin
            w_emask[i] = '0;
        end
    end
`endif

    // Compare against the pre-edge array so a SEARCH sees only earlier ops
    always_comb begin
        for (int i = 0; i < int'(CAM_DEPTH); i++) begin
            w_match[i] = r_valid[i] && (((r_data[i] ^ op_data) & ~w_emask[i]) == '0);
        end
    end

    always_comb begin
        w_free_idx = '0;
        w_free_any = 1'b0;
        for (int i = int'(CAM_DEPTH) - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_idx = IDX_W'(i);
                w_free_any = 1'b1;
            end
        end
    end

    assign w_adv_s2 = !r_rsp_vld || rsp_rdy;
    assign w_adv_s1 = !r_s1_vld || w_adv_s2;
    assign op_rdy   = w_adv_s1;
    assign w_accept = op_vld && w_adv_s1;

    assign w_idx_ok  = (32'(op_idx) < CAM_DEPTH);
    assign w_idx_vld = w_idx_ok && r_valid[op_idx];

    // Array side effects of the accepted op
    always_comb begin
        w_set_en   = 1'b0;
        w_set_idx  = op_idx;
        w_clr_en   = 1'b0;
        w_cnt_inc  = 1'b0;
        w_cnt_dec  = 1'b0;
        w_op_hit   = 1'b0;
        w_op_index = op_idx;
        case (op_code)
            OP_WRITE: begin
                w_op_hit  = w_idx_ok;
                w_set_en  = w_accept && w_idx_ok;
                w_cnt_inc = w_accept && w_idx_ok && !w_idx_vld;
            end
            OP_INSERT: begin
                w_op_hit   = w_free_any;
                w_op_index = w_free_any ? w_free_idx : '0;
                w_set_idx  = w_free_idx;
                w_set_en   = w_accept && w_free_any;
                w_cnt_inc  = w_accept && w_free_any;
            end
            OP_INVAL: begin
                w_op_hit  = w_idx_vld;
                w_clr_en  = w_accept && w_idx_ok;
                w_cnt_dec = w_accept && w_idx_vld;
            end
            default: begin
                w_op_hit = 1'b0;
            end
        endcase
        w_cnt_nxt = r_cnt + CNT_W'(w_cnt_inc) - CNT_W'(w_cnt_dec);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_cnt   <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_set_en) begin
                r_valid[w_set_idx] <= 1'b1;
            end
            if (w_clr_en) begin
                r_valid[op_idx] <= 1'b0;
            end
            r_cnt  <= w_cnt_nxt;
            r_full <= (32'(w_cnt_nxt) == CAM_DEPTH);
        end
    end

    // Key storage needs no reset; validity is tracked separately
    always_ff @(posedge clk) begin
        if (w_set_en) begin
            r_data[w_set_idx] <= op_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vld   <= 1'b0;
            r_s1_srch  <= 1'b0;
            r_s1_match <= '0;
            r_s1_hit   <= 1'b0;
            r_s1_idx   <= '0;
        end else if (w_adv_s1) begin
            r_s1_vld   <= w_accept;
            r_s1_srch  <= (op_code == OP_SEARCH);
            r_s1_match <= w_match;
            r_s1_hit   <= w_op_hit;
            r_s1_idx   <= w_op_index;
        end
    end

    // Lowest-index priority encode of the registered match vector
    always_comb begin
        w_enc_idx = '0;
        for (int i = int'(CAM_DEPTH) - 1; i >= 0; i--) begin
            if (r_s1_match[i]) begin
                w_enc_idx = IDX_W'(i);
            end
        end
    end

    assign w_enc_hit   = |r_s1_match;
    assign w_enc_multi = |(r_s1_match & (r_s1_match - CAM_DEPTH'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_vld   <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_multi <= 1'b0;
            r_rsp_index <= '0;
        end else if (w_adv_s2) begin
            r_rsp_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_rsp_hit   <= r_s1_srch ? w_enc_hit : r_s1_hit;
                r_rsp_multi <= r_s1_srch ? w_enc_multi : 1'b0;
                r_rsp_index <= r_s1_srch ? w_enc_idx : r_s1_idx;
            end
        end
    end

    assign rsp_vld   = r_rsp_vld;
    assign rsp_hit   = r_rsp_hit;
    assign rsp_multi = r_rsp_multi;
    assign rsp_index = r_rsp_index;
    assign used_cnt  = r_cnt;
    assign full      = r_full;

endmodule

// File: tb/tb_cam_pipe.sv
// Self-checking bench for cam_pipe: directed vector table, corner sequences and
// randomized ops scored against an array/queue reference model.
module tb_cam_pipe;

    localparam int unsigned W  = 32;
    localparam int unsigned D  = 16;
    localparam int unsigned IW = 4;
    localparam int unsigned CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_vld = 1'b0;
    logic          op_rdy;
    logic [1:0]    op_code = 2'd0;
    logic [IW-1:0] op_idx = '0;
    logic [W-1:0]  op_data = '0;
`ifdef CAM_TERNARY_EN
    logic [W-1:0]  op_mask = '0;
`endif
    logic          rsp_vld;
    logic          rsp_rdy = 1'b1;
    logic          rsp_hit;
    logic          rsp_multi;
    logic [IW-1:0] rsp_index;
    logic [CW-1:0] used_cnt;
    logic          full;

    cam_pipe #(.CAM_WIDTH(W), .CAM_DEPTH(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .op_vld    (op_vld),
        .op_rdy    (op_rdy),
        .op_code   (op_code),
        .op_idx    (op_idx),
        .op_data   (op_data),
`ifdef CAM_TERNARY_EN
        .op_mask   (op_mask),
`endif
        .rsp_vld   (rsp_vld),
        .rsp_rdy   (rsp_rdy),
        .rsp_hit   (rsp_hit),
        .rsp_multi (rsp_multi),
        .rsp_index (rsp_index),
        .used_cnt  (used_cnt),
        .full      (full)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endfunction

    // Reference model: plain arrays plus a queue of expected responses
    typedef struct { bit hit; bit multi; int idx; } exp_t;
    logic [W-1:0] m_data  [D];
    logic [W-1:0] m_mask  [D];
    bit           m_valid [D];
    int           m_cnt = 0;
    exp_t         exp_q [$];

    function automatic void model_reset();
        for (int i = 0; i < int'(D); i++) m_valid[i] = 1'b0;
        m_cnt = 0;
        exp_q.delete();
    endfunction

    function automatic void model_apply(input logic [1:0] c, input int idx,
                                        input logic [W-1:0] d, input logic [W-1:0] m);
        exp_t e;
        int   nm;
        int   f;
        e = '{0, 0, 0};
        nm = 0;
        f = -1;
        case (c)
            2'd0: begin
                for (int i = 0; i < int'(D); i++)
                    if (m_valid[i] && (((m_data[i] ^ d) & ~m_mask[i]) == '0)) begin
                        if (nm == 0) e.idx = i;
                        nm++;
                    end
                e.hit = (nm > 0);
                e.multi = (nm > 1);
            end
            2'd1: begin
                e.hit = 1; e.idx = idx;
                if (!m_valid[idx]) m_cnt++;
                m_valid[idx] = 1; m_data[idx] = d; m_mask[idx] = m;
            end
            2'd2: begin
                for (int i = int'(D) - 1; i >= 0; i--) if (!m_valid[i]) f = i;
                if (f >= 0) begin
                    e.hit = 1; e.idx = f; m_cnt++;
                    m_valid[f] = 1; m_data[f] = d; m_mask[f] = m;
                end
            end
            default: begin
                e.idx = idx; e.hit = m_valid[idx];
                if (m_valid[idx]) m_cnt--;
                m_valid[idx] = 0;
            end
        endcase
        exp_q.push_back(e);
    endfunction

    // Response monitor: backpressure, in-order scoreboard, hold-while-stalled, occupancy
    int           rdy_mode = 0;
    int           rsp_seen = 0;
    bit           stall_hold = 0;
    logic         h_hit, h_multi, l_hit, l_multi;
    logic [IW-1:0] h_idx, l_idx;

    always @(negedge clk) begin
        case (rdy_mode)
            0:       rsp_rdy = 1'b1;
            1:       rsp_rdy = ($urandom_range(0, 3) != 0);
            default: rsp_rdy = 1'b0;
        endcase
        if (rst) begin
            stall_hold = 0;
        end else begin
            if (stall_hold) begin
                chk("rsp_hold_vld", int'(rsp_vld), 1);
                chk("rsp_hold_data", int'({rsp_hit, rsp_multi, rsp_index}),
                    int'({h_hit, h_multi, h_idx}));
            end
            if (rsp_vld && rsp_rdy) begin
                exp_t e;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rsp: got response hit=%0d idx=%0d with none pending",
                             rsp_hit, rsp_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_hit", int'(rsp_hit), int'(e.hit));
                    chk("sb_multi", int'(rsp_multi), int'(e.multi));
                    chk("sb_index", int'(rsp_index), e.idx);
                end
                l_hit = rsp_hit; l_multi = rsp_multi; l_idx = rsp_index;
                rsp_seen++;
            end
            stall_hold = rsp_vld && !rsp_rdy;
            h_hit = rsp_hit; h_multi = rsp_multi; h_idx = rsp_index;
            chk("used_cnt", int'(used_cnt), m_cnt);
            chk("full", int'(full), int'(m_cnt == int'(D)));
        end
    end

    int acc_cnt = 0;

    task automatic do_op(input logic [1:0] c, input int idx, input logic [W-1:0] d,
                         input logic [W-1:0] m);
        bit done;
        int guard;
        done = 0;
        guard = 0;
        @(negedge clk);
        op_vld = 1'b1; op_code = c; op_idx = IW'(idx); op_data = d;
`ifdef CAM_TERNARY_EN
        op_mask = m;
`endif
        while (!done) begin
            #1;
            if (op_rdy) begin
                @(posedge clk);
`ifdef CAM_TERNARY_EN
                model_apply(c, idx, d, m);
`else
                model_apply(c, idx, d, '0);
`endif
                acc_cnt++;
                done = 1;
                #1 op_vld = 1'b0;
            end else begin
                @(posedge clk);
                guard++;
                if (guard > 200) begin
                    checks++; failures++;
                    $display("FAIL accept_timeout: op_rdy low for %0d cycles, required high", guard);
                    op_vld = 1'b0;
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (exp_q.size() != 0 && g < 500) begin
            @(negedge clk); #1; g++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
        end
    endtask

    typedef struct {
        logic [1:0] code; int idx; logic [W-1:0] data;
        bit hit; bit multi; int ridx; int cnt;
    } vec_t;

    // One op, wait for its response, compare against the vector's expectation (-1 = skip)
    task automatic run_vec(input string nm, input vec_t v, input logic [W-1:0] m);
        int start;
        int g;
        start = rsp_seen;
        g = 0;
        do_op(v.code, v.idx, v.data, m);
        while (rsp_seen == start && g < 50) begin
            @(negedge clk); #1; g++;
        end
        checks++;
        if (rsp_seen == start) begin
            failures++;
            $display("FAIL %s_timeout: no response after %0d cycles, required one", nm, g);
        end else begin
            chk({nm, "_hit"}, int'(l_hit), int'(v.hit));
            chk({nm, "_multi"}, int'(l_multi), int'(v.multi));
            if (v.ridx >= 0) chk({nm, "_index"}, int'(l_idx), v.ridx);
            if (v.cnt >= 0) begin
                chk({nm, "_cnt"}, int'(used_cnt), v.cnt);
                chk({nm, "_full"}, int'(full), int'(v.cnt == int'(D)));
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[12];
    vec_t v;
    int   free_order[13];

    initial begin
        tbl[0]  = '{2'd0, 0, 32'h0000_0000, 0, 0, 0, 0};
        tbl[1]  = '{2'd2, 0, 32'hA5A5_0001, 1, 0, 0, 1};
        tbl[2]  = '{2'd2, 0, 32'h0000_1234, 1, 0, 1, 2};
        tbl[3]  = '{2'd0, 0, 32'h0000_1234, 1, 0, 1, 2};
        tbl[4]  = '{2'd1, 3, 32'h0000_DEAD, 1, 0, 3, 3};
        tbl[5]  = '{2'd1, 7, 32'h0000_DEAD, 1, 0, 7, 4};
        tbl[6]  = '{2'd0, 0, 32'h0000_DEAD, 1, 1, 3, 4};
        tbl[7]  = '{2'd3, 3, 32'h0000_0000, 1, 0, 3, 3};
        tbl[8]  = '{2'd0, 0, 32'h0000_DEAD, 1, 0, 7, 3};
        tbl[9]  = '{2'd3, 3, 32'h0000_0000, 0, 0, 3, 3};
        tbl[10] = '{2'd1, 7, 32'h0000_BEEF, 1, 0, 7, 3};
        tbl[11] = '{2'd0, 0, 32'h0000_DEAD, 0, 0, 0, 3};
        free_order = '{2, 3, 4, 5, 6, 8, 9, 10, 11, 12, 13, 14, 15};

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst = 1'b0;
        @(negedge clk); #1;
        chk("rst_rsp_vld", int'(rsp_vld), 0);
        chk("rst_rsp_hit", int'(rsp_hit), 0);
        chk("rst_rsp_multi", int'(rsp_multi), 0);
        chk("rst_rsp_index", int'(rsp_index), 0);
        chk("rst_used_cnt", int'(used_cnt), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_op_rdy", int'(op_rdy), 1);

        for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), tbl[i], '0);

        // Fill the remaining 13 free slots, lowest-index first
        for (int i = 0; i < 13; i++) begin
            v = '{2'd2, 0, 32'h1000_0000 + 32'(i), 1, 0, free_order[i], 4 + i};
            run_vec($sformatf("fill%0d", i), v, '0);
        end
        v = '{2'd2, 0, 32'hCAFE_F00D, 0, 0, 0, 16};  run_vec("ins_full", v, '0);
        v = '{2'd0, 0, 32'hCAFE_F00D, 0, 0, 0, 16};  run_vec("srch_rejected", v, '0);
        v = '{2'd3, 5, 32'h0,         1, 0, 5, 15};  run_vec("inval5", v, '0);
        v = '{2'd2, 0, 32'h0000_5555, 1, 0, 5, 16};  run_vec("reins5", v, '0);
        v = '{2'd0, 0, 32'h0000_5555, 1, 0, 5, 16};  run_vec("srch5", v, '0);

        // Back-to-back WRITE then SEARCH of the same key must hit
        do_op(2'd1, 9, 32'h0ABC_D123, '0);
        do_op(2'd0, 0, 32'h0ABC_D123, '0);
        drain();
        chk("b2b_last_hit", int'(l_hit), 1);
        chk("b2b_last_index", int'(l_idx), 9);

        // Stream of 8 searches against a stalled response channel
        begin
            int a0;
            a0 = acc_cnt;
            rdy_mode = 2;
            fork
                for (int i = 0; i < 8; i++) do_op(2'd0, 0, 32'h1000_0000 + 32'(i), '0);
                begin
                    repeat (6) @(negedge clk);
                    #1;
                    chk("stall_accepts", acc_cnt - a0, 2);
                    chk("stall_op_rdy", int'(op_rdy), 0);
                    rdy_mode = 0;
                end
            join
            drain();
        end

`ifdef CAM_TERNARY_EN
        v = '{2'd1, 2, 32'h0000_FF00, 1, 0, 2, -1};  run_vec("tern_wr", v, 32'h0000_00FF);
        v = '{2'd0, 0, 32'h0000_FF3C, 1, 0, -1, -1}; run_vec("tern_srch", v, '0);
`endif

        // Randomized mix with random backpressure and bubbles
        rdy_mode = 1;
        for (int n = 0; n < 400; n++) begin
            int r;
            logic [1:0] c;
            r = $urandom_range(0, 9);
            c = (r < 4) ? 2'd0 : (r < 6) ? 2'd1 : (r < 8) ? 2'd2 : 2'd3;
            do_op(c, $urandom_range(0, int'(D) - 1), 32'h0000_7700 + 32'($urandom_range(0, 11)), '0);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();

        // Reset with two ops in flight drops both responses
        rdy_mode = 2;
        do_op(2'd3, 0, 32'h0, '0);
        do_op(2'd3, 1, 32'h0, '0);
        @(negedge clk); #2 rst = 1'b1;
        model_reset();
        @(negedge clk); #2 rst = 1'b0;
        rdy_mode = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("post_rst_rsp_vld", int'(rsp_vld), 0);
        end
        chk("post_rst_used_cnt", int'(used_cnt), 0);
        chk("post_rst_full", int'(full), 0);
        v = '{2'd2, 0, 32'h0000_0042, 1, 0, 0, 1};   run_vec("post_rst_ins", v, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
